alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: grant, issue, capture, respond.
// Define ALU_ARB_FIXED_PRIO_EN to replace round-robin arbitration with fixed priority (requester 0 wins).
module alu_arbiter #(
  parameter logic [2:0] IDLE_OP = 3'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_data,
  output logic        rsp0_flag_z,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_data,
  output logic        rsp1_flag_z,
  output logic        rsp1_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_c,
  input  logic        alu_flag_z,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        gnt_q;
  logic [2:0]  op_q;
  logic [2:0]  alu_op_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic [15:0] data_q;
  logic        z_q;
  logic        err_q;
  logic [1:0]  rsp_valid_q;
  logic        busy_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic        last_q;
`endif

  logic        gnt_s;
  logic        accept_s;
  logic        rsp_ready_s;
  logic [2:0]  op_s;
  logic [15:0] a_s;
  logic [15:0] b_s;

  function automatic logic op_illegal(input logic [2:0] op);
    return (op == 3'd4) || (op == 3'd7);
  endfunction

  // Only SUB forwards the ALU flag; PASS reports whether operand a was zero.
  function automatic logic zero_flag(input logic [2:0] op, input logic [15:0] a, input logic alu_z);
    logic f;
    case (op)
      3'd1:    f = alu_z;
      3'd2:    f = (a == 16'd0);
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  // Grant selection among the currently valid requesters.
  always_comb begin
    gnt_s = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt_s = 1'b0;
`else
      gnt_s = ~last_q;
`endif
    end else if (req1_valid) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  assign accept_s    = rst_n && (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = accept_s && !gnt_s;
  assign req1_ready  = accept_s && gnt_s;
  assign op_s        = gnt_s ? req1_op : req0_op;
  assign a_s         = gnt_s ? req1_a : req0_a;
  assign b_s         = gnt_s ? req1_b : req0_b;
  assign rsp_ready_s = gnt_q ? rsp1_ready : rsp0_ready;

  // Operation sequencer: IDLE accepts, EXEC drives the ALU, RESP holds the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      op_q        <= 3'd0;
      alu_op_q    <= IDLE_OP;
      alu_a_q     <= 16'd0;
      alu_b_q     <= 16'd0;
      data_q      <= 16'd0;
      z_q         <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            state_q  <= S_EXEC;
            gnt_q    <= gnt_s;
            op_q     <= op_s;
            alu_op_q <= op_illegal(op_s) ? IDLE_OP : op_s;
            alu_a_q  <= a_s;
            alu_b_q  <= b_s;
            busy_q   <= 1'b1;
          end
        end
        S_EXEC: begin
          state_q     <= S_RESP;
          data_q      <= op_illegal(op_q) ? 16'd0 : alu_c;
          z_q         <= zero_flag(op_q, alu_a_q, alu_flag_z);
          err_q       <= op_illegal(op_q);
          rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
        end
        S_RESP: begin
          if (rsp_ready_s) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            alu_op_q    <= IDLE_OP;
            alu_a_q     <= 16'd0;
            alu_b_q     <= 16'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q      <= gnt_q;
`endif
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          alu_op_q    <= IDLE_OP;
          alu_a_q     <= 16'd0;
          alu_b_q     <= 16'd0;
        end
      endcase
    end
  end

  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_data   = data_q;
  assign rsp1_data   = data_q;
  assign rsp0_flag_z = z_q;
  assign rsp1_flag_z = z_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_alu_arbiter;
  localparam logic [2:0] IDLE_OP = 3'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic [15:0] req0_a = 16'd0, req0_b = 16'd0, req1_a = 16'd0, req1_b = 16'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [15:0] rsp0_data, rsp1_data;
  logic        rsp0_flag_z, rsp1_flag_z, rsp0_err, rsp1_err;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        alu_flag_z;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // Transaction-level reference: one op in flight at most, with its accept cycle.
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  int          m_req = 0;
  int          m_acc = 0;
  int          cyc = 0;
  logic [2:0]  m_op = 3'd0;
  logic [15:0] m_a = 16'd0, m_b = 16'd0;

  alu_arbiter #(.IDLE_OP(IDLE_OP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_flag_z(rsp0_flag_z),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_flag_z(rsp1_flag_z),
    .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_flag_z(alu_flag_z), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared ALU: 0 ADD, 1 SUB (flag = borrow), 2 PASS b, 3 AND, 5 SHR by b[3:0], 6 XOR.
  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return b;
      3'd3:    return a & b;
      3'd5:    return a >> b[3:0];
      3'd6:    return a ^ b;
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic logic ref_flag(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 3'd1) return a < b;
    return ref_alu(op, a, b) == 16'd0;
  endfunction

  assign alu_c      = ref_alu(alu_op, alu_a, alu_b);
  assign alu_flag_z = ref_flag(alu_op, alu_a, alu_b);

  function automatic bit illegal(input logic [2:0] op);
    return (op == 3'd4) || (op == 3'd7);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Sample on the falling edge, compare every output with the model, then advance the model.
  task automatic sample();
    int w;
    int age;
    logic [15:0] e_data;
    logic e_z;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      check("rst_req0_ready", 16'(req0_ready), 16'd0);
      check("rst_req1_ready", 16'(req1_ready), 16'd0);
      check("rst_rsp_valid", 16'({rsp1_valid, rsp0_valid}), 16'd0);
      check("rst_rsp0_data", rsp0_data, 16'd0);
      check("rst_rsp1_data", rsp1_data, 16'd0);
      check("rst_flags", 16'({rsp0_flag_z, rsp1_flag_z, rsp0_err, rsp1_err}), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_alu_op", 16'(alu_op), 16'(IDLE_OP));
      check("rst_alu_a", alu_a, 16'd0);
      check("rst_alu_b", alu_b, 16'd0);
      m_busy = 1'b0;
      m_last = 1'b1;
      return;
    end
    w = -1;
    if (!m_busy) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = m_last ? 0 : 1;
`endif
      end else if (req1_valid) begin
        w = 1;
      end else if (req0_valid) begin
        w = 0;
      end
    end
    age = cyc - m_acc;
    check("req0_ready", 16'(req0_ready), 16'(w == 0));
    check("req1_ready", 16'(req1_ready), 16'(w == 1));
    check("busy", 16'(busy), 16'(m_busy));
    check("alu_op", 16'(alu_op), m_busy ? 16'(illegal(m_op) ? IDLE_OP : m_op) : 16'(IDLE_OP));
    check("alu_a", alu_a, m_busy ? m_a : 16'd0);
    check("alu_b", alu_b, m_busy ? m_b : 16'd0);
    check("rsp0_valid", 16'(rsp0_valid), 16'(m_busy && age >= 2 && m_req == 0));
    check("rsp1_valid", 16'(rsp1_valid), 16'(m_busy && age >= 2 && m_req == 1));
    if (m_busy && age >= 2) begin
      e_data = illegal(m_op) ? 16'd0 : ref_alu(m_op, m_a, m_b);
      e_z = (m_op == 3'd1) ? (m_a < m_b) : ((m_op == 3'd2) ? (m_a == 16'd0) : 1'b0);
      check("rsp_data", m_req ? rsp1_data : rsp0_data, e_data);
      check("rsp_flag_z", 16'(m_req ? rsp1_flag_z : rsp0_flag_z), 16'(e_z));
      check("rsp_err", 16'(m_req ? rsp1_err : rsp0_err), 16'(illegal(m_op)));
      if (m_req ? rsp1_ready : rsp0_ready) begin
        m_busy = 1'b0;
        m_last = (m_req == 1);
      end
    end else if (w >= 0) begin
      m_busy = 1'b1;
      m_req = w;
      m_acc = cyc;
      m_op = w ? req1_op : req0_op;
      m_a = w ? req1_a : req0_a;
      m_b = w ? req1_b : req0_b;
    end
  endtask

  task automatic drive(input int n, input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // One complete operation with the response taken immediately.
  task automatic do_op(input int n, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] e_data, input logic e_z, input logic e_err, input logic [2:0] e_aop);
    drive(n, 1'b1, op, a, b);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    sample();
    check("op_accept", 16'(n ? req1_ready : req0_ready), 16'd1);
    adv();
    drive(n, 1'b0, 3'd0, 16'd0, 16'd0);
    sample();
    check("op_exec_alu_op", 16'(alu_op), 16'(e_aop));
    check("op_exec_no_rsp", 16'(n ? rsp1_valid : rsp0_valid), 16'd0);
    adv();
    sample();
    check("op_rsp_valid_at_2", 16'(n ? rsp1_valid : rsp0_valid), 16'd1);
    check("op_rsp_data", n ? rsp1_data : rsp0_data, e_data);
    check("op_rsp_flag_z", 16'(n ? rsp1_flag_z : rsp0_flag_z), 16'(e_z));
    check("op_rsp_err", 16'(n ? rsp1_err : rsp0_err), 16'(e_err));
    adv();
    sample();
    check("op_done_idle", 16'(busy), 16'd0);
    adv();
  endtask

  initial begin
    int grants[$];
    logic [15:0] held;

    // Reset with requests pending: no ready may leak out.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    sample();
    adv();
    drive(0, 1'b0, 3'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    sample();
    adv();

    do_op(0, 3'd0, 16'h08F5, 16'h0485, 16'h0D7A, 1'b0, 1'b0, 3'd0);
    do_op(0, 3'd7, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b1, IDLE_OP);
    do_op(1, 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 3'd1);
    do_op(1, 3'd2, 16'h0005, 16'h1234, 16'h1234, 1'b0, 1'b0, 3'd2);

    // Both requesters held valid: round-robin alternates, fixed priority serves only 0.
    drive(0, 1'b1, 3'd5, 16'h4001, 16'd12);
    drive(1, 1'b1, 3'd6, 16'h0003, 16'd2);
    for (int i = 0; i < 12; i++) begin
      sample();
      if (req0_valid && req0_ready) grants.push_back(0);
      if (req1_valid && req1_ready) grants.push_back(1);
      if (rsp0_valid) check("rr_rsp0_data", rsp0_data, 16'h0004);
      if (rsp1_valid) check("rr_rsp1_data", rsp1_data, 16'h0001);
      adv();
    end
    drive(0, 1'b0, 3'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0);
    check("rr_grant_count", 16'(grants.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("fixed_grant", 16'((i < grants.size()) ? grants[i] : 9), 16'd0);
`else
      check("rr_grant", 16'((i < grants.size()) ? grants[i] : 9), 16'(i % 2));
`endif
    end
    sample();
    adv();

    // Back-pressure on requester 0 while requester 1 waits.
    drive(0, 1'b1, 3'd0, 16'h0001, 16'h0002);
    drive(1, 1'b1, 3'd0, 16'h0010, 16'h0020);
    rsp0_ready = 1'b0;
    sample();
    check("bp_accept0", 16'(req0_ready), 16'd1);
    adv();
    drive(0, 1'b0, 3'd0, 16'd0, 16'd0);
    sample();
    adv();
    held = rsp0_data;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("bp_rsp0_valid", 16'(rsp0_valid), 16'd1);
      check("bp_rsp0_data", rsp0_data, 16'h0003);
      check("bp_busy", 16'(busy), 16'd1);
      check("bp_req1_ready", 16'(req1_ready), 16'd0);
      adv();
    end
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0);
    rsp0_ready = 1'b1;
    sample();
    adv();
    sample();
    adv();

    // Reset during EXEC discards the operation; requester 0 wins the first tie afterwards.
    drive(1, 1'b1, 3'd0, 16'h0007, 16'h0001);
    sample();
    adv();
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_rsp1_valid", 16'(rsp1_valid), 16'd0);
    check("mid_rst_alu_op", 16'(alu_op), 16'(IDLE_OP));
    check("mid_rst_alu_a", alu_a, 16'd0);
    sample();
    adv();
    rst_n = 1'b1;
    drive(0, 1'b1, 3'd2, 16'h0000, 16'h00AA);
    drive(1, 1'b1, 3'd0, 16'h0001, 16'h0001);
    sample();
    check("post_rst_first_grant0", 16'(req0_ready), 16'd1);
    check("post_rst_no_grant1", 16'(req1_ready), 16'd0);
    adv();
    drive(0, 1'b0, 3'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      sample();
      adv();
    end

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      req0_a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      req1_a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      req0_b = 16'($urandom);
      req1_b = 16'($urandom);
      rsp0_ready = ($urandom_range(0, 1) == 1);
      rsp1_ready = ($urandom_range(0, 1) == 1);
      sample();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
